// File: rtl/ctrl_hazard_predictor_if.sv
// Pipeline <-> control-hazard predictor connection.
// The pipeline side (master) drives the DE/EX stage information and receives
// the prediction bit, the next-PC override and the flush requests.
interface ctrl_hazard_predictor_if #(
    parameter int XLEN = 32
);
    logic            de_valid;
    logic [6:0]      de_opcode;
    logic [XLEN-1:0] de_pc;
    logic [XLEN-1:0] de_B_Immed;
    logic [XLEN-1:0] de_J_Immed;

    logic            ex_valid;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_func3;
    logic            BR_EQ;
    logic            BR_LT;
    logic            BR_LTU;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_B_Immed;
    logic [XLEN-1:0] ex_I_Immed;
    logic [XLEN-1:0] ex_rs1;
    logic            ex_pred_taken;

    logic            de_pred_taken;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if;
    logic            flush_de;
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;

    modport master (
        output de_valid, de_opcode, de_pc, de_B_Immed, de_J_Immed,
        output ex_valid, ex_opcode, ex_func3, BR_EQ, BR_LT, BR_LTU,
        output ex_pc, ex_B_Immed, ex_I_Immed, ex_rs1, ex_pred_taken,
        input  de_pred_taken, redirect, redirect_pc, flush_if, flush_de,
        input  perf_branches, perf_mispredicts
    );

    modport slave (
        input  de_valid, de_opcode, de_pc, de_B_Immed, de_J_Immed,
        input  ex_valid, ex_opcode, ex_func3, BR_EQ, BR_LT, BR_LTU,
        input  ex_pc, ex_B_Immed, ex_I_Immed, ex_rs1, ex_pred_taken,
        output de_pred_taken, redirect, redirect_pc, flush_if, flush_de,
        output perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/ctrl_hazard_predictor.sv
// Control-hazard logic with a direct-mapped 2-bit branch history table.
// Branches are predicted in DE (JAL and predicted-taken branches redirect
// from DE); branches resolve in EX, where mispredicts and JALR redirect.
// Optional macro CHP_PERF_CNT_EN adds branch/mispredict event counters;
// without it the perf outputs are tied to zero.
module ctrl_hazard_predictor #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CTR_INIT  = 2'b01
) (
    input logic                   CLK,
    input logic                   RST_N,
    ctrl_hazard_predictor_if.slave bus
);
    localparam int IDX = $clog2(BHT_DEPTH);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [1:0]      bht [BHT_DEPTH];
    logic [IDX-1:0]  de_idx;
    logic [IDX-1:0]  ex_idx;
    logic            ex_taken;
    logic            func3_ok;
    logic            ex_update;
    logic            ex_mis;
    logic            ex_jalr;
    logic            de_jal;
    logic            de_pred;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_if;
    logic            flush_de;

    assign de_idx = bus.de_pc[IDX+1:2];
    assign ex_idx = bus.ex_pc[IDX+1:2];

    // Resolve the branch direction from funct3; 010/011 are not branches.
    always_comb begin
        ex_taken = 1'b0;
        func3_ok = 1'b1;
        case (bus.ex_func3)
            3'b000:  ex_taken = bus.BR_EQ;
            3'b001:  ex_taken = !bus.BR_EQ;
            3'b100:  ex_taken = bus.BR_LT;
            3'b101:  ex_taken = !bus.BR_LT;
            3'b110:  ex_taken = bus.BR_LTU;
            3'b111:  ex_taken = !bus.BR_LTU;
            default: func3_ok = 1'b0;
        endcase
    end

    assign ex_update = bus.ex_valid && (bus.ex_opcode == OP_BRANCH) && func3_ok;
    assign ex_mis    = ex_update && (ex_taken != bus.ex_pred_taken);
    assign ex_jalr   = bus.ex_valid && (bus.ex_opcode == OP_JALR);
    assign de_jal    = bus.de_valid && (bus.de_opcode == OP_JAL);
    // Array read sees the pre-update value, so a same-cycle EX write is not bypassed.
    assign de_pred   = bus.de_valid && (bus.de_opcode == OP_BRANCH) && bht[de_idx][1];

    // Redirect priority: EX JALR, EX mispredict, DE JAL, DE predicted-taken.
    always_comb begin
        redirect    = 1'b0;
        redirect_pc = '0;
        flush_if    = 1'b0;
        flush_de    = 1'b0;
        if (ex_jalr) begin
            redirect    = 1'b1;
            redirect_pc = (bus.ex_rs1 + bus.ex_I_Immed) & ~XLEN'(1);
            flush_if    = 1'b1;
            flush_de    = 1'b1;
        end else if (ex_mis) begin
            redirect    = 1'b1;
            redirect_pc = ex_taken ? (bus.ex_pc + bus.ex_B_Immed) : (bus.ex_pc + XLEN'(4));
            flush_if    = 1'b1;
            flush_de    = 1'b1;
        end else if (de_jal) begin
            redirect    = 1'b1;
            redirect_pc = bus.de_pc + bus.de_J_Immed;
            flush_if    = 1'b1;
        end else if (de_pred) begin
            redirect    = 1'b1;
            redirect_pc = bus.de_pc + bus.de_B_Immed;
            flush_if    = 1'b1;
        end
    end

    assign bus.de_pred_taken = de_pred;
    assign bus.redirect      = redirect;
    assign bus.redirect_pc   = redirect_pc;
    assign bus.flush_if      = flush_if;
    assign bus.flush_de      = flush_de;

    // Train the saturating counter of every resolved conditional branch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CTR_INIT;
            end
        end else if (ex_update) begin
            if (ex_taken) begin
                if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
            end else begin
                if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
            end
        end
    end

`ifdef CHP_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (ex_update) perf_branches    <= perf_branches + 32'd1;
            if (ex_mis)    perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end

    assign bus.perf_branches    = perf_branches;
    assign bus.perf_mispredicts = perf_mispredicts;
`else
    assign bus.perf_branches    = '0;
    assign bus.perf_mispredicts = '0;
`endif
endmodule

// File: tb/tb_ctrl_hazard_predictor.sv
// Bench for ctrl_hazard_predictor: directed vector table, a perf/reset
// sequence and randomized traffic checked against a counter-array model.
module tb_ctrl_hazard_predictor;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] ALU  = 7'b0110011;

    typedef struct {
        logic        de_valid;
        logic [6:0]  de_op;
        logic [31:0] de_pc, de_b, de_j;
        logic        ex_valid;
        logic [6:0]  ex_op;
        logic [2:0]  f3;
        logic        eq, lt, ltu;
        logic [31:0] ex_pc, ex_b, ex_i, ex_rs1;
        logic        ex_pt;
    } stim_t;

    typedef struct {
        logic        pt;
        logic        red;
        logic [31:0] rpc;
        logic        fi;
        logic        fd;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ctrl_hazard_predictor_if #(.XLEN(32)) bus ();

    ctrl_hazard_predictor #(.XLEN(32), .BHT_DEPTH(64), .CTR_INIT(2'b01)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ctr [64];
    int unsigned m_branches = 0;
    int unsigned m_mis      = 0;
    vec_t        tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) ctr[i] = 1;
        m_branches = 0;
        m_mis      = 0;
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    // Reference: direction from funct3 rules, counters as integers 0..3.
    function automatic void model_eval(input stim_t s, output exp_t e,
                                       output bit upd, output bit tk, output bit mis);
        bit is_br, f3ok, jalr, jal, pt;
        tk = 0;
        f3ok = 1;
        case (s.f3)
            3'd0: tk = s.eq;
            3'd1: tk = !s.eq;
            3'd4: tk = s.lt;
            3'd5: tk = !s.lt;
            3'd6: tk = s.ltu;
            3'd7: tk = !s.ltu;
            default: f3ok = 0;
        endcase
        is_br = s.ex_valid && (s.ex_op == BR);
        upd   = is_br && f3ok;
        mis   = upd && (tk != s.ex_pt);
        jalr  = s.ex_valid && (s.ex_op == JALR);
        jal   = s.de_valid && (s.de_op == JAL);
        pt    = s.de_valid && (s.de_op == BR) && (ctr[idx_of(s.de_pc)] >= 2);
        e.pt = pt;
        e.red = 1; e.fi = 1; e.fd = 0; e.rpc = 32'd0;
        if (jalr) begin
            e.rpc = (s.ex_rs1 + s.ex_i) & 32'hFFFF_FFFE;
            e.fd  = 1;
        end else if (mis) begin
            e.rpc = tk ? s.ex_pc + s.ex_b : s.ex_pc + 32'd4;
            e.fd  = 1;
        end else if (jal) begin
            e.rpc = s.de_pc + s.de_j;
        end else if (pt) begin
            e.rpc = s.de_pc + s.de_b;
        end else begin
            e.red = 0; e.fi = 0;
        end
    endfunction

    function automatic void model_commit(input stim_t s, input bit upd, input bit tk, input bit mis);
        int k;
        k = idx_of(s.ex_pc);
        if (upd) begin
            if (tk) ctr[k] = (ctr[k] == 3) ? 3 : ctr[k] + 1;
            else    ctr[k] = (ctr[k] == 0) ? 0 : ctr[k] - 1;
            m_branches++;
        end
        if (mis) m_mis++;
    endfunction

    task automatic drive(input stim_t s);
        bus.de_valid      = s.de_valid;
        bus.de_opcode     = s.de_op;
        bus.de_pc         = s.de_pc;
        bus.de_B_Immed    = s.de_b;
        bus.de_J_Immed    = s.de_j;
        bus.ex_valid      = s.ex_valid;
        bus.ex_opcode     = s.ex_op;
        bus.ex_func3      = s.f3;
        bus.BR_EQ         = s.eq;
        bus.BR_LT         = s.lt;
        bus.BR_LTU        = s.ltu;
        bus.ex_pc         = s.ex_pc;
        bus.ex_B_Immed    = s.ex_b;
        bus.ex_I_Immed    = s.ex_i;
        bus.ex_rs1        = s.ex_rs1;
        bus.ex_pred_taken = s.ex_pt;
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, " de_pred_taken"}, {31'd0, bus.de_pred_taken}, {31'd0, e.pt});
        check({tag, " redirect"},      {31'd0, bus.redirect},      {31'd0, e.red});
        check({tag, " redirect_pc"},   bus.redirect_pc,            e.rpc);
        check({tag, " flush_if"},      {31'd0, bus.flush_if},      {31'd0, e.fi});
        check({tag, " flush_de"},      {31'd0, bus.flush_de},      {31'd0, e.fd});
    endtask

    task automatic check_perf(input string tag, input logic [31:0] eb, input logic [31:0] em);
`ifdef CHP_PERF_CNT_EN
        check({tag, " perf_branches"},    bus.perf_branches,    eb);
        check({tag, " perf_mispredicts"}, bus.perf_mispredicts, em);
`else
        check({tag, " perf_branches"},    bus.perf_branches,    32'd0);
        check({tag, " perf_mispredicts"}, bus.perf_mispredicts, 32'd0);
`endif
    endtask

    // One cycle: drive at posedge+1, sample at posedge+4, clock, commit model.
    task automatic cycle(input stim_t s, output exp_t mdl);
        bit upd, tk, mis;
        drive(s);
        model_eval(s, mdl, upd, tk, mis);
        #3;
        @(posedge clk);
        #1;
        model_commit(s, upd, tk, mis);
    endtask

    task automatic cycle_check(input stim_t s, input exp_t e, input string tag);
        bit upd, tk, mis;
        exp_t mdl;
        drive(s);
        model_eval(s, mdl, upd, tk, mis);
        #3;
        check_out(tag, e);
        @(posedge clk);
        #1;
        model_commit(s, upd, tk, mis);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.de_valid = 0; s.de_op = ALU; s.de_pc = 0; s.de_b = 0; s.de_j = 0;
        s.ex_valid = 0; s.ex_op = ALU; s.f3 = 0; s.eq = 0; s.lt = 0; s.ltu = 0;
        s.ex_pc = 0; s.ex_b = 0; s.ex_i = 0; s.ex_rs1 = 0; s.ex_pt = 0;
        return s;
    endfunction

    function automatic stim_t with_de(input stim_t s, input logic [6:0] op,
                                      input logic [31:0] pc, input logic [31:0] b, input logic [31:0] j);
        s.de_valid = 1; s.de_op = op; s.de_pc = pc; s.de_b = b; s.de_j = j;
        return s;
    endfunction

    function automatic stim_t with_ex(input stim_t s, input logic [2:0] f3, input logic [31:0] pc,
                                      input logic pt, input logic eq, input logic lt, input logic ltu);
        s.ex_valid = 1; s.ex_op = BR; s.f3 = f3; s.ex_pc = pc; s.ex_b = 32'h20;
        s.ex_pt = pt; s.eq = eq; s.lt = lt; s.ltu = ltu;
        return s;
    endfunction

    function automatic exp_t ex(input logic pt, input logic red, input logic [31:0] rpc,
                                input logic fi, input logic fd);
        exp_t e;
        e.pt = pt; e.red = red; e.rpc = rpc; e.fi = fi; e.fd = fd;
        return e;
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 5))
            0, 1, 2: return BR;
            3:       return JAL;
            4:       return JALR;
            default: return ALU;
        endcase
    endfunction

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 3) == 0) return $urandom;
        return $urandom & 32'h0000_03FC;
    endfunction

    initial begin
        stim_t s;
        exp_t  e;
        stim_t z;

        z = idle();
        drive(z);
        model_reset();

        tbl[0]  = '{with_de(z, BR, 32'h100, 32'h20, 0), ex(0, 0, 0, 0, 0)};
        tbl[1]  = '{with_ex(with_de(z, BR, 32'h100, 32'h20, 0), 3'd0, 32'h100, 0, 1, 0, 0),
                    ex(0, 1, 32'h120, 1, 1)};
        tbl[2]  = '{with_de(z, BR, 32'h100, 32'h20, 0), ex(1, 1, 32'h120, 1, 0)};
        for (int i = 3; i <= 6; i++)
            tbl[i] = '{with_ex(z, 3'd0, 32'h100, 1, 1, 0, 0), ex(0, 0, 0, 0, 0)};
        tbl[7]  = '{with_ex(with_de(z, BR, 32'h100, 32'h20, 0), 3'd1, 32'h100, 1, 1, 0, 0),
                    ex(1, 1, 32'h104, 1, 1)};
        tbl[8]  = '{with_de(z, BR, 32'h100, 32'h20, 0), ex(1, 1, 32'h120, 1, 0)};
        s = with_de(z, JAL, 32'h300, 0, 32'h40);
        s.ex_valid = 1; s.ex_op = JALR; s.ex_rs1 = 32'h2001; s.ex_i = 32'h4;
        tbl[9]  = '{s, ex(0, 1, 32'h2004, 1, 1)};
        tbl[10] = '{with_de(z, JAL, 32'h300, 0, 32'h40), ex(0, 1, 32'h340, 1, 0)};
        tbl[11] = '{with_ex(z, 3'd0, 32'h100, 1, 1, 0, 0), ex(0, 0, 0, 0, 0)};
        tbl[12] = '{with_ex(with_de(z, BR, 32'h200, 32'h10, 0), 3'd2, 32'h100, 1, 1, 1, 1),
                    ex(1, 1, 32'h210, 1, 0)};
        tbl[13] = '{with_ex(z, 3'd0, 32'h100, 1, 0, 0, 0), ex(0, 1, 32'h104, 1, 1)};
        tbl[14] = '{with_de(z, BR, 32'h200, 32'h10, 0), ex(1, 1, 32'h210, 1, 0)};
        s = with_ex(with_de(z, BR, 32'h100, 32'h20, 0), 3'd0, 32'h100, 1, 0, 0, 0);
        s.ex_valid = 0; s.de_valid = 0;
        tbl[15] = '{s, ex(0, 0, 0, 0, 0)};
        tbl[16] = '{with_de(z, BR, 32'h100, 32'h20, 0), ex(1, 1, 32'h120, 1, 0)};
        tbl[17] = '{with_ex(z, 3'd1, 32'h100, 0, 1, 0, 0), ex(0, 0, 0, 0, 0)};
        tbl[18] = '{with_de(z, BR, 32'h100, 32'h20, 0), ex(0, 0, 0, 0, 0)};

        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_perf("reset", 32'd0, 32'd0);

        for (int i = 0; i < 19; i++) begin
            cycle_check(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Perf sequence: 5 resolved branches, 2 of them mispredicted.
        do_reset();
        cycle_check(with_ex(z, 3'd0, 32'h40, 1, 1, 0, 0), ex(0, 0, 0, 0, 0), "perf beq");
        cycle_check(with_ex(z, 3'd0, 32'h44, 0, 0, 0, 0), ex(0, 0, 0, 0, 0), "perf beq_nt");
        cycle_check(with_ex(z, 3'd1, 32'h48, 1, 1, 0, 0), ex(0, 1, 32'h4C, 1, 1), "perf bne_mis");
        cycle_check(with_ex(z, 3'd4, 32'h4C, 0, 0, 1, 0), ex(0, 1, 32'h6C, 1, 1), "perf blt_mis");
        cycle_check(with_ex(z, 3'd7, 32'h50, 1, 0, 0, 0), ex(0, 0, 0, 0, 0), "perf bgeu");
        drive(z);
        #3;
        check_perf("perf after 5", 32'd5, 32'd2);
        rst_n = 1'b0;
        #1;
        check_perf("perf in reset", 32'd0, 32'd0);
        #3;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Mid-operation reset discards history.
        cycle(with_ex(z, 3'd0, 32'h100, 0, 1, 0, 0), e);
        cycle(with_ex(z, 3'd0, 32'h100, 1, 1, 0, 0), e);
        drive(with_de(z, BR, 32'h100, 32'h20, 0));
        #2;
        check("trained pred", {31'd0, bus.de_pred_taken}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("pred in reset", {31'd0, bus.de_pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle_check(with_de(z, BR, 32'h100, 32'h20, 0), ex(0, 0, 0, 0, 0), "post-reset");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bit upd, tk, mis;
            s.de_valid = ($urandom_range(0, 3) != 0);
            s.de_op    = rand_op();
            s.de_pc    = rand_pc();
            s.de_b     = $urandom;
            s.de_j     = $urandom;
            s.ex_valid = ($urandom_range(0, 3) != 0);
            s.ex_op    = rand_op();
            s.f3       = 3'($urandom_range(0, 7));
            s.eq       = 1'($urandom);
            s.lt       = 1'($urandom);
            s.ltu      = 1'($urandom);
            s.ex_pc    = rand_pc();
            s.ex_b     = $urandom;
            s.ex_i     = $urandom;
            s.ex_rs1   = $urandom;
            s.ex_pt    = (ctr[idx_of(s.ex_pc)] >= 2) ^ ($urandom_range(0, 3) == 0);
            drive(s);
            model_eval(s, e, upd, tk, mis);
            #3;
            check_out($sformatf("rnd%0d", n), e);
            if ((n % 100) == 99) check_perf($sformatf("rnd%0d", n), m_branches, m_mis);
            @(posedge clk);
            #1;
            model_commit(s, upd, tk, mis);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
